// File: rtl/controle_multiciclo.sv
// controle_multiciclo
//   Multicycle control FSM for a small RV32 core. Sequences each instruction
//   through FETCH/DECODE/EXEC/MEM/WB (or BRANCH), then one PC_UPD cycle in
//   which the downstream PC block advances using pcsrc. Memory handshakes are
//   bounded by a wait counter; an expired wait or an unknown opcode stops the
//   core in HALT until rst_n.
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   opcode, funct3      instruction fields from the instruction register
//   zero                ALU zero flag, used while in BRANCH
//   if_ack, mem_ack     instruction / data memory acknowledges
//   estado              current state encoding
//   pcsrc               registered branch-taken select, valid in PC_UPD
//   if_req, ir_write    instruction fetch request / IR latch enable
//   mem_read, mem_write data memory requests
//   reg_write, alu_src, alu_op, mem_to_reg   datapath controls
//   halt, err           core stopped / stopped because of a timeout
module controle_multiciclo #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       if_ack,
   input  logic       mem_ack,
   output logic [3:0] estado,
   output logic       pcsrc,
   output logic       if_req,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       alu_src,
   output logic [1:0] alu_op,
   output logic       mem_to_reg,
   output logic       halt,
   output logic       err
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'b0000,
      S_DECODE = 4'b0001,
      S_EXEC   = 4'b0010,
      S_MEM    = 4'b0011,
      S_WB     = 4'b0100,
      S_BRANCH = 4'b0101,
      S_PC_UPD = 4'b1000,
      S_HALT   = 4'b1111
   } state_t;

   // Instruction class captured in DECODE so later states do not depend on
   // the opcode input staying stable.
   typedef enum logic [1:0] {
      CLS_R  = 2'b00,
      CLS_I  = 2'b01,
      CLS_LD = 2'b10,
      CLS_ST = 2'b11
   } cls_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   // Last count value a wait may reach; no ack there means timeout.
   localparam logic [7:0] LAST_WAIT_C = 8'(MEM_TIMEOUT - 1);

   state_t     state_r, next_s;
   cls_t       cls_r, cls_s;
   logic [7:0] wait_r;
   logic       err_r, pcsrc_r;
   logic       wait_last_s, taken_s, timeout_s;
   logic       if_req_s, ir_write_s, mem_read_s, mem_write_s;
   logic       reg_write_s, alu_src_s, mem_to_reg_s;
   logic [1:0] alu_op_s;

   assign wait_last_s = (wait_r == LAST_WAIT_C);

   // Next-state, decode and control outputs for the current state.
   always_comb begin
      next_s       = state_r;
      cls_s        = cls_r;
      taken_s      = 1'b0;
      timeout_s    = 1'b0;
      if_req_s     = 1'b0;
      ir_write_s   = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      reg_write_s  = 1'b0;
      alu_src_s    = 1'b0;
      alu_op_s     = 2'b00;
      mem_to_reg_s = 1'b0;
      case (state_r)
         S_FETCH: begin
            if_req_s = 1'b1;
            if (if_ack) begin
               ir_write_s = 1'b1;
               next_s     = S_DECODE;
            end else if (wait_last_s) begin
               timeout_s = 1'b1;
               next_s    = S_HALT;
            end else begin
               next_s = S_FETCH;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_R:    begin cls_s = CLS_R;  next_s = S_EXEC; end
               OP_I:    begin cls_s = CLS_I;  next_s = S_EXEC; end
               OP_LD:   begin cls_s = CLS_LD; next_s = S_EXEC; end
               OP_ST:   begin cls_s = CLS_ST; next_s = S_EXEC; end
               OP_BR:   next_s = S_BRANCH;
               default: next_s = S_HALT;
            endcase
         end
         S_EXEC: begin
            alu_src_s = (cls_r != CLS_R);
            if (cls_r == CLS_LD || cls_r == CLS_ST) begin
               alu_op_s = 2'b00;
               next_s   = S_MEM;
            end else begin
               alu_op_s = 2'b10;
               next_s   = S_WB;
            end
         end
         S_MEM: begin
            mem_read_s  = (cls_r == CLS_LD);
            mem_write_s = (cls_r != CLS_LD);
            if (mem_ack) begin
               next_s = (cls_r == CLS_LD) ? S_WB : S_PC_UPD;
            end else if (wait_last_s) begin
               timeout_s = 1'b1;
               next_s    = S_HALT;
            end else begin
               next_s = S_MEM;
            end
         end
         S_WB: begin
            reg_write_s  = 1'b1;
            mem_to_reg_s = (cls_r == CLS_LD);
            next_s       = S_PC_UPD;
         end
         S_BRANCH: begin
            alu_op_s = 2'b01;
            case (funct3)
               3'b000:  taken_s = zero;
               3'b001:  taken_s = ~zero;
               default: taken_s = 1'b0;
            endcase
            next_s = S_PC_UPD;
         end
         S_PC_UPD: next_s = S_FETCH;
         S_HALT:   next_s = S_HALT;
         default:  next_s = S_HALT;
      endcase
   end

   // State, instruction class, sticky error and branch select registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
         cls_r   <= CLS_R;
         err_r   <= 1'b0;
         pcsrc_r <= 1'b0;
      end else begin
         state_r <= next_s;
         cls_r   <= cls_s;
         err_r   <= err_r | timeout_s;
         // Only the BRANCH->PC_UPD edge can set pcsrc; every other edge clears it.
         pcsrc_r <= (state_r == S_BRANCH) ? taken_s : 1'b0;
      end
   end

   // Handshake wait counter: restarts on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_r <= 8'd0;
      end else if (next_s != state_r) begin
         wait_r <= 8'd0;
      end else if (state_r == S_FETCH || state_r == S_MEM) begin
         wait_r <= wait_r + 8'd1;
      end else begin
         wait_r <= 8'd0;
      end
   end

   // FETCH drives if_req combinationally, so outputs are gated to stay quiet in reset.
   assign estado     = state_r;
   assign pcsrc      = pcsrc_r;
   assign if_req     = rst_n & if_req_s;
   assign ir_write   = rst_n & ir_write_s;
   assign mem_read   = rst_n & mem_read_s;
   assign mem_write  = rst_n & mem_write_s;
   assign reg_write  = rst_n & reg_write_s;
   assign alu_src    = rst_n & alu_src_s;
   assign alu_op     = {2{rst_n}} & alu_op_s;
   assign mem_to_reg = rst_n & mem_to_reg_s;
   assign halt       = (state_r == S_HALT);
   assign err        = err_r;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo. A trace generator turns each instruction
// (kind, funct3, zero, ack delays) into the per-cycle input/expected-output
// sequence the control must produce; one loop drives and compares it.
module tb_controle_multiciclo;

   localparam int T    = 16;
   localparam int K_R  = 0;
   localparam int K_I  = 1;
   localparam int K_LD = 2;
   localparam int K_ST = 3;
   localparam int K_BR = 4;
   localparam int K_IL = 5;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [6:0] opcode  = 7'd0;
   logic [2:0] funct3  = 3'd0;
   logic       zero    = 1'b0;
   logic       if_ack  = 1'b0;
   logic       mem_ack = 1'b0;
   logic [3:0] estado;
   logic       pcsrc, if_req, ir_write, mem_read, mem_write, reg_write, alu_src;
   logic [1:0] alu_op;
   logic       mem_to_reg, halt, err;
   logic [15:0] act;

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        z;
      logic        ia;
      logic        ma;
      logic [15:0] exp;
   } cyc_t;

   cyc_t  q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   string tag;

   always #5 clk = ~clk;

   controle_multiciclo #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
      .if_ack(if_ack), .mem_ack(mem_ack), .estado(estado), .pcsrc(pcsrc),
      .if_req(if_req), .ir_write(ir_write), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .alu_src(alu_src),
      .alu_op(alu_op), .mem_to_reg(mem_to_reg), .halt(halt), .err(err)
   );

   assign act = {estado, pcsrc, if_req, ir_write, mem_read, mem_write,
                 reg_write, alu_src, alu_op, mem_to_reg, halt, err};

   function automatic logic [15:0] mk(input logic [3:0] st, input logic pc, ifr, irw,
                                      mr, mw, rw, as, input logic [1:0] aop,
                                      input logic m2r, h, e);
      return {st, pc, ifr, irw, mr, mw, rw, as, aop, m2r, h, e};
   endfunction

   function automatic logic [6:0] opc_of(input int k);
      case (k)
         K_R:     return 7'b0110011;
         K_I:     return 7'b0010011;
         K_LD:    return 7'b0000011;
         K_ST:    return 7'b0100011;
         K_BR:    return 7'b1100011;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] a, input logic [15:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
      end
   endtask

   task automatic check_int(input string name, input int a, input int e);
      n_tests++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, a, e);
      end
   endtask

   task automatic push(input logic [6:0] o, input logic [2:0] f, input logic z_i,
                       input logic ia, input logic ma, input logic [15:0] e);
      cyc_t c;
      c.opc = o; c.f3 = f; c.z = z_i; c.ia = ia; c.ma = ma; c.exp = e;
      q.push_back(c);
   endtask

   // Expected trace of one instruction; ncyc counts cycles up to PC_UPD or HALT entry.
   task automatic add_instr(input int k, input logic [2:0] f, input logic z_i,
                            input int if_dly, input int mem_dly,
                            output int ncyc, output logic halted, output logic herr);
      logic [6:0] o;
      int         n;
      logic       tk, mrd, mwr;
      o = opc_of(k);
      ncyc = 0; halted = 1'b0; herr = 1'b0;
      n = (if_dly >= T) ? T : if_dly;
      for (int i = 0; i < n; i++) begin
         push(o, f, z_i, 1'b0, 1'b0, mk(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
         ncyc++;
      end
      if (if_dly >= T) begin
         halted = 1'b1; herr = 1'b1;
         return;
      end
      push(o, f, z_i, 1'b1, 1'b0, mk(4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      push(o, f, z_i, 1'b0, 1'b0, mk(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      ncyc += 2;
      if (k == K_IL) begin
         halted = 1'b1;
         return;
      end
      if (k == K_BR) begin
         tk = (f == 3'b000 && z_i) || (f == 3'b001 && !z_i);
         push(o, f, z_i, 1'b0, 1'b0, mk(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
         push(o, f, z_i, 1'b0, 1'b0, mk(4'h8, tk, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
         ncyc += 2;
         return;
      end
      push(o, f, z_i, 1'b0, 1'b0, mk(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k != K_R),
                                     (k == K_R || k == K_I) ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b0));
      ncyc++;
      if (k == K_LD || k == K_ST) begin
         mrd = (k == K_LD);
         mwr = !mrd;
         n = (mem_dly >= T) ? T : mem_dly;
         for (int i = 0; i < n; i++) begin
            push(o, f, z_i, 1'b0, 1'b0, mk(4'h3, 1'b0, 1'b0, 1'b0, mrd, mwr, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            ncyc++;
         end
         if (mem_dly >= T) begin
            halted = 1'b1; herr = 1'b1;
            return;
         end
         push(o, f, z_i, 1'b0, 1'b1, mk(4'h3, 1'b0, 1'b0, 1'b0, mrd, mwr, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
         ncyc++;
         if (k == K_ST) begin
            push(o, f, z_i, 1'b0, 1'b0, mk(4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            ncyc++;
            return;
         end
      end
      push(o, f, z_i, 1'b0, 1'b0, mk(4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, (k == K_LD), 1'b0, 1'b0));
      push(o, f, z_i, 1'b0, 1'b0, mk(4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      ncyc += 2;
   endtask

   // HALT cycles with stray acks that must be ignored.
   task automatic add_halt(input logic e, input int k);
      for (int i = 0; i < k; i++) begin
         push(7'b1111111, 3'b000, 1'b0, (i % 2 == 0), (i % 2 == 1),
              mk(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, e));
      end
   endtask

   // Entered and left on a falling edge: drive, settle, compare.
   task automatic run_q();
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         opcode = c.opc; funct3 = c.f3; zero = c.z; if_ack = c.ia; mem_ack = c.ma;
         #2;
         check(tag, act, c.exp);
         @(negedge clk);
      end
   endtask

   // Async reset between edges; acks held high to show requests stay low.
   task automatic do_reset();
      #1;
      rst_n = 1'b0; if_ack = 1'b1; mem_ack = 1'b1;
      #1;
      check("reset_outputs", act, 16'h0000);
      @(negedge clk);
      if_ack = 1'b0; mem_ack = 1'b0; rst_n = 1'b1;
   endtask

   logic [2:0] bf3 [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
   logic       bz  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   int         btk [5] = '{1, 0, 1, 0, 0};

   initial begin
      int   nc, seq;
      logic h, he;

      do_reset();

      tag = "r_type";
      add_instr(K_R, 3'b000, 1'b0, 0, 0, nc, h, he);
      check_int("lat_alu", nc, 5);
      seq = int'({q[0].exp[15:12], q[1].exp[15:12], q[2].exp[15:12], q[3].exp[15:12], q[4].exp[15:12]});
      check_int("r_seq", seq, 32'h00001248);
      run_q();

      tag = "i_alu_fetch_wait2";
      add_instr(K_I, 3'b010, 1'b0, 2, 0, nc, h, he);
      check_int("lat_i_d2", nc, 7);
      run_q();

      for (int i = 0; i < 5; i++) begin
         tag = $sformatf("branch%0d", i);
         add_instr(K_BR, bf3[i], bz[i], 0, 0, nc, h, he);
         check_int("lat_branch", nc, 4);
         check_int($sformatf("branch%0d_taken", i), int'(q[3].exp[11]), btk[i]);
         run_q();
      end

      tag = "load_ack3";
      add_instr(K_LD, 3'b010, 1'b0, 0, 3, nc, h, he);
      check_int("lat_load_d3", nc, 9);
      run_q();

      tag = "load";
      add_instr(K_LD, 3'b010, 1'b0, 0, 0, nc, h, he);
      check_int("lat_load", nc, 6);
      run_q();

      tag = "store";
      add_instr(K_ST, 3'b010, 1'b0, 0, 0, nc, h, he);
      check_int("lat_store", nc, 5);
      run_q();

      tag = "load_ack_last";
      add_instr(K_LD, 3'b010, 1'b0, 0, T - 1, nc, h, he);
      run_q();

      tag = "fetch_ack_last";
      add_instr(K_R, 3'b000, 1'b0, T - 1, 0, nc, h, he);
      run_q();

      tag = "illegal";
      add_instr(K_IL, 3'b000, 1'b0, 0, 0, nc, h, he);
      check_int("lat_illegal", nc, 2);
      add_halt(1'b0, 4);
      run_q();
      do_reset();

      tag = "store_timeout";
      add_instr(K_ST, 3'b000, 1'b0, 0, T, nc, h, he);
      check_int("lat_store_to", nc, 19);
      add_halt(1'b1, 4);
      run_q();
      check_int("err_sticky", int'(err), 1);
      do_reset();

      tag = "fetch_timeout";
      add_instr(K_R, 3'b000, 1'b0, T, 0, nc, h, he);
      add_halt(1'b1, 3);
      run_q();
      do_reset();

      tag = "mid_mem";
      add_instr(K_LD, 3'b000, 1'b0, 0, 10, nc, h, he);
      while (q.size() > 5) q.delete(q.size() - 1);
      run_q();
      mem_ack = 1'b0;
      #1;
      check("mid_mem_req", act, mk(4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      do_reset();

      tag = "after_reset";
      add_instr(K_R, 3'b000, 1'b0, 0, 0, nc, h, he);
      run_q();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
